spi_apb_bridge: RTL and testbench
=================================

SPI_APB_BRIDGE -- requirements
Module: spi_apb_bridge

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving TX and RX FIFO depth in bytes (power of two, 2..16).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have ports psel_i, penable_i and pwrite_i, each input, 1 bit: APB3 control.
REQ-005 The block SHALL have port paddr_bi, input, 4 bits: byte address (0x0 CTRL, 0x4 STATUS, 0x8 TXDATA, 0xC RXDATA).
REQ-006 The block SHALL have ports pwdata_bi (input, 32 bits) and prdata_bo (output, 32 bits): APB write and read data.
REQ-007 The block SHALL have ports pready_o and pslverr_o, each output, 1 bit: APB completion and error.
REQ-008 The block SHALL have ports m_start_o (output, 1 bit) and m_data_bo (output, 8 bits): start strobe and TX byte to spi_master_driver.
REQ-009 The block SHALL have ports m_busy_i (input, 1 bit) and m_data_bi (input, 8 bits): busy flag and RX byte from spi_master_driver.
REQ-010 With SPI_APB_IRQ_EN defined, the block SHALL have port irq_o, output, 1 bit: level interrupt.

Function
REQ-011 pready_o SHALL be 1 in every cycle, giving zero-wait-state transfers; a transfer completes when psel_i=penable_i=1.
REQ-012 CTRL SHALL be read/write: bit0 EN (sequencer enable), bit1 IRQEN; all other bits read 0 and writes to them are ignored.
REQ-013 STATUS SHALL be read-only: bit0 TX_EMPTY, bit1 TX_FULL, bit2 RX_EMPTY, bit3 RX_FULL, bit4 BUSY (FSM not IDLE), bits[15:8] TX level, bits[23:16] RX level.
REQ-014 A TXDATA write SHALL push pwdata_bi[7:0]; if TX is full, data SHALL be dropped and pslverr_o=1 in the access phase.
REQ-015 An RXDATA read SHALL return the RX head in bits[7:0] and pop it; if RX is empty, prdata_bo SHALL be 0 with pslverr_o=1 and no pop.
REQ-016 A write to STATUS or a read of TXDATA SHALL return pslverr_o=1 with no side effect; all other accesses SHALL return pslverr_o=0.
REQ-017 prdata_bo SHALL be driven combinationally during the access phase and SHALL be 0 otherwise.
REQ-018 The sequencer FSM SHALL have four states: IDLE, LAUNCH, XFER and CAPTURE.
REQ-019 IDLE->LAUNCH SHALL occur when EN=1, TX is not empty and RX is not full; on that edge the TX head SHALL be popped into m_data_bo.
REQ-020 In LAUNCH m_start_o SHALL be 1; the FSM SHALL go LAUNCH->XFER on the first cycle m_busy_i=1.
REQ-021 XFER->CAPTURE SHALL occur on the first cycle m_busy_i=0; CAPTURE SHALL push m_data_bi into RX and return to IDLE after 1 cycle.
REQ-022 m_data_bo SHALL hold its value from LAUNCH until the next launch.
REQ-023 Clearing EN mid-transfer SHALL NOT abort the transfer; the FSM SHALL finish CAPTURE and then stay in IDLE.
REQ-024 Simultaneous APB push and FSM pop on TX, or APB pop and FSM push on RX, SHALL both take effect with the level unchanged, including when full or empty.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; levels SHALL range 0..FIFO_DEPTH.

Reset
REQ-026 With rst_n_i=0 the block SHALL asynchronously force: FSM=IDLE, FIFOs empty, CTRL=0, m_start_o=0, m_data_bo=0, pslverr_o=0, prdata_bo=0, irq_o=0.
REQ-027 Reset SHALL release synchronously; asserting reset mid-transfer SHALL discard the in-flight byte and all FIFO contents.

Configuration
REQ-028 With macro SPI_APB_IRQ_EN defined, irq_o SHALL be IRQEN & (RX_EMPTY==0), registered; without it irq_o SHALL be absent, and CTRL bit1 SHALL read 0 and ignore writes.

Verification
REQ-029 Reset, then write CTRL=0x1 and TXDATA=0xAC with the slave loaded with 0x65 -> m_start_o pulses, MOSI carries 0xAC, and RXDATA reads 0x65 with pslverr=0.
REQ-030 Write 5 bytes with EN=0 and FIFO_DEPTH=4 -> the 5th write gives pslverr=1 and STATUS reads TX level 4 with TX_FULL=1.
REQ-031 Read RXDATA when empty -> prdata=0 and pslverr=1; STATUS then shows RX_EMPTY=1.
REQ-032 Queue 0x99 and 0x11, then drop rst_n_i during the first XFER -> outputs immediately match REQ-026, STATUS=0x05, and no second start occurs.
REQ-033 Fill RX to 4 with EN=1 and TX holding 1 byte -> no launch; one RXDATA read -> launch occurs within 2 cycles.
REQ-034 With SPI_APB_IRQ_EN defined and CTRL=0x3, one completed transfer -> irq_o=1; irq_o falls after the RXDATA read empties RX.

Source files
------------

// File: rtl/spi_apb_bridge.sv
// APB3 register front-end feeding an SPI master driver through TX/RX byte FIFOs.
// Optional level interrupt output irq_o is built when SPI_APB_IRQ_EN is defined.
module spi_apb_bridge #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [3:0]  paddr_bi,
  input  logic [31:0] pwdata_bi,
  output logic [31:0] prdata_bo,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        m_start_o,
  output logic [7:0]  m_data_bo,
  input  logic        m_busy_i,
  input  logic [7:0]  m_data_bi
`ifdef SPI_APB_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_XFER,
    ST_CAPTURE
  } state_t;

  state_t state;

  logic          ctrl_en;
  logic          ctrl_irqen;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0] tx_lvl, rx_lvl;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic access, sel_ctrl, sel_stat, sel_tx, sel_rx;
  logic tx_wr_req, rx_rd_req, tx_push, tx_pop, rx_push, rx_pop;
  logic launch_ok, err;
  logic [7:0]  rx_head;
  logic [31:0] status, rdata;
  logic unused;

  assign unused = ^{pwdata_bi[31:8], pwdata_bi[1], paddr_bi[1:0]};

  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = (tx_lvl == LW'(FIFO_DEPTH));
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = (rx_lvl == LW'(FIFO_DEPTH));

  assign access   = psel_i & penable_i;
  assign sel_ctrl = (paddr_bi[3:2] == 2'd0);
  assign sel_stat = (paddr_bi[3:2] == 2'd1);
  assign sel_tx   = (paddr_bi[3:2] == 2'd2);
  assign sel_rx   = (paddr_bi[3:2] == 2'd3);

  assign launch_ok = ctrl_en & ~tx_empty & ~rx_full;
  assign tx_pop    = (state == ST_IDLE) & launch_ok;
  assign rx_push   = (state == ST_CAPTURE);

  // A push into a full TX is accepted when the sequencer pops on the same edge;
  // a pop from an empty RX is accepted when the sequencer pushes (byte bypassed).
  assign tx_wr_req = access & pwrite_i & sel_tx;
  assign rx_rd_req = access & ~pwrite_i & sel_rx;
  assign tx_push   = tx_wr_req & (~tx_full | tx_pop);
  assign rx_pop    = rx_rd_req & (~rx_empty | rx_push);
  assign rx_head   = rx_empty ? m_data_bi : rx_mem[rx_rp];

  assign err = (tx_wr_req & ~tx_push) | (rx_rd_req & ~rx_pop) |
               (access & pwrite_i & sel_stat) | (access & ~pwrite_i & sel_tx);

  assign status = {8'd0, 8'(rx_lvl), 8'(tx_lvl), 3'd0,
                   (state != ST_IDLE), rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rdata = '0;
    if (sel_ctrl)      rdata = {30'd0, ctrl_irqen, ctrl_en};
    else if (sel_stat) rdata = status;
    else if (sel_rx && rx_pop) rdata = {24'd0, rx_head};
  end

  assign pready_o  = 1'b1;
  assign pslverr_o = rst_n_i & err;
  assign prdata_bo = (rst_n_i & access & ~pwrite_i) ? rdata : 32'd0;

  // Control register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_en <= 1'b0;
    end else if (access && pwrite_i && sel_ctrl) begin
      ctrl_en <= pwdata_bi[0];
    end
  end

`ifdef SPI_APB_IRQ_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_irqen <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      if (access && pwrite_i && sel_ctrl) ctrl_irqen <= pwdata_bi[1];
      irq_o <= ctrl_irqen & ~rx_empty;
    end
  end
`else
  assign ctrl_irqen = 1'b0;
`endif

  // FIFO storage (no reset needed, validity tracked by levels)
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp] <= pwdata_bi[7:0];
    if (rx_push) rx_mem[rx_wp] <= m_data_bi;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_lvl <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_lvl <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_lvl <= tx_lvl + LW'(1);
        2'b01:   tx_lvl <= tx_lvl - LW'(1);
        default: tx_lvl <= tx_lvl;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_lvl <= rx_lvl + LW'(1);
        2'b01:   rx_lvl <= rx_lvl - LW'(1);
        default: rx_lvl <= rx_lvl;
      endcase
    end
  end

  // Transfer sequencer; EN only gates new launches, never aborts one in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      m_start_o <= 1'b0;
      m_data_bo <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch_ok) begin
            state     <= ST_LAUNCH;
            m_start_o <= 1'b1;
            m_data_bo <= tx_mem[tx_rp];
          end
        end
        ST_LAUNCH: begin
          if (m_busy_i) begin
            state     <= ST_XFER;
            m_start_o <= 1'b0;
          end
        end
        ST_XFER: begin
          if (!m_busy_i) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          m_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Directed self-checking bench for spi_apb_bridge with a simple SPI master driver model.
module tb_spi_apb_bridge;

`ifdef SPI_APB_IRQ_EN
  localparam logic [31:0] EXP_CTRL_ALL = 32'h3;
`else
  localparam logic [31:0] EXP_CTRL_ALL = 32'h1;
`endif

  logic        clk, rst_n, psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, m_start, m_busy;
  logic [7:0]  m_data_o, m_data_i;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int busy_cnt = 0;
  logic [7:0] last_mosi = 8'd0;
  logic [7:0] key = 8'd0;

  spi_apb_bridge #(.FIFO_DEPTH(4)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .psel_i   (psel),
    .penable_i(penable),
    .pwrite_i (pwrite),
    .paddr_bi (paddr),
    .pwdata_bi(pwdata),
    .prdata_bo(prdata),
    .pready_o (pready),
    .pslverr_o(pslverr),
    .m_start_o(m_start),
    .m_data_bo(m_data_o),
    .m_busy_i (m_busy),
    .m_data_bi(m_data_i)
`ifdef SPI_APB_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );

`ifndef SPI_APB_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    #1 d = prdata; err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  // SPI master driver model: busy for a few cycles, returns mosi ^ key
  initial begin
    m_busy = 1'b0;
    m_data_i = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
      end else if (m_start && !m_busy) begin
        m_busy = 1'b1;
        busy_cnt = 3;
        last_mosi = m_data_o;
        m_data_i = m_data_o ^ key;
        starts++;
      end else if (m_busy) begin
        if (busy_cnt == 0) m_busy = 1'b0;
        else busy_cnt--;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        err;
    logic [31:0] d;
    logic        seen;
    int          s0;

    rst_n = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    paddr = 4'hC; pwdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_m_start", {31'd0, m_start}, 32'd0);
    check("rst_m_data", {24'd0, m_data_o}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("pready", {31'd0, pready}, 32'd1);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    apb_read(4'h4, d, err);
    check("status_reset", d, 32'h0000_0005);
    apb_read(4'h0, d, err);
    check("ctrl_reset", d, 32'd0);

    // Single byte round trip
    key = 8'hC9;
    apb_write(4'h0, 32'h1, err);
    apb_write(4'h8, 32'h0000_00AC, err);
    check("tx_wr_err", {31'd0, err}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_start) begin seen = 1'b1; break; end
    end
    check("start_pulse", {31'd0, seen}, 32'd1);
    check("mosi_byte", {24'd0, m_data_o}, 32'h0000_00AC);
    repeat (15) @(posedge clk);
    check("mosi_model", {24'd0, last_mosi}, 32'h0000_00AC);
    apb_read(4'h4, d, err);
    check("status_rx1", d, 32'h0001_0001);
    apb_read(4'hC, d, err);
    check("rx_data", d, 32'h0000_0065);
    check("rx_err", {31'd0, err}, 32'd0);
    check("starts_1", starts, 1);

    // Overfill TX with sequencer disabled
    apb_write(4'h0, 32'h0, err);
    for (int i = 1; i <= 5; i++) begin
      apb_write(4'h8, 32'(i), err);
      check($sformatf("tx_push%0d_err", i), {31'd0, err}, (i == 5) ? 32'd1 : 32'd0);
    end
    apb_read(4'h4, d, err);
    check("status_txfull", d, 32'h0000_0406);
    apb_read(4'h8, d, err);
    check("rd_txdata_err", {31'd0, err}, 32'd1);
    apb_write(4'h4, 32'hFFFF_FFFF, err);
    check("wr_status_err", {31'd0, err}, 32'd1);
    apb_read(4'hC, d, err);
    check("rx_empty_data", d, 32'd0);
    check("rx_empty_err", {31'd0, err}, 32'd1);
    apb_read(4'h4, d, err);
    check("status_after_err", d, 32'h0000_0406);

    // Drain TX into RX until RX is full
    key = 8'h00;
    apb_write(4'h0, 32'hFFFF_FFFF, err);
    apb_read(4'h0, d, err);
    check("ctrl_mask", d, EXP_CTRL_ALL);
    repeat (60) @(posedge clk);
    check("starts_5", starts, 5);
    apb_read(4'h4, d, err);
    check("status_rxfull", d, 32'h0004_0009);
`ifdef SPI_APB_IRQ_EN
    check("irq_set", {31'd0, irq}, 32'd1);
`endif
    apb_write(4'h8, 32'h77, err);
    repeat (10) @(posedge clk);
    check("no_launch_rxfull", starts, 5);
    apb_read(4'h4, d, err);
    check("status_blocked", d, 32'h0004_0108);
    apb_read(4'hC, d, err);
    check("rx_pop1", d, 32'h0000_0001);
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (m_start) begin seen = 1'b1; break; end
    end
    check("launch_after_pop", {31'd0, seen}, 32'd1);
    repeat (15) @(posedge clk);
    apb_read(4'hC, d, err);
    check("rx_pop2", d, 32'h0000_0002);
    apb_read(4'hC, d, err);
    check("rx_pop3", d, 32'h0000_0003);
    apb_read(4'hC, d, err);
    check("rx_pop4", d, 32'h0000_0004);
    apb_read(4'hC, d, err);
    check("rx_pop5", d, 32'h0000_0077);
    repeat (2) @(posedge clk);
    #1;
`ifdef SPI_APB_IRQ_EN
    check("irq_clear", {31'd0, irq}, 32'd0);
`endif
    apb_read(4'h4, d, err);
    check("status_drained", d, 32'h0000_0005);

    // Reset in the middle of a transfer
    apb_write(4'h0, 32'h0, err);
    apb_write(4'h8, 32'h99, err);
    apb_write(4'h8, 32'h11, err);
    apb_write(4'h0, 32'h1, err);
    apb_read(4'h4, d, err);
    check("status_busy", d, 32'h0000_0114);
    check("mosi_99", {24'd0, m_data_o}, 32'h0000_0099);
    s0 = starts;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_data", {24'd0, m_data_o}, 32'd0);
    check("mid_rst_m_start", {31'd0, m_start}, 32'd0);
    check("mid_rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("mid_rst_prdata", prdata, 32'd0);
    check("mid_rst_irq", {31'd0, irq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apb_read(4'h4, d, err);
    check("status_post_rst", d, 32'h0000_0005);
    apb_read(4'h0, d, err);
    check("ctrl_post_rst", d, 32'd0);
    repeat (30) @(posedge clk);
    check("no_second_start", starts, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
